io_responder: RTL and testbench

IO_RESPONDER -- requirements
Module: io_responder

---
 rtl/io_responder_pkg.sv | 16 +
 rtl/io_responder_if.sv | 10 +
 rtl/seven_seg_decoder.sv | 9 +
 rtl/io_responder.sv | 87 ++++++++
 tb/tb_io_responder.sv | 139 +++++++++++++
 5 files changed

// File: rtl/io_responder_pkg.sv
// io_responder_pkg: memory-map constants and 7-segment glyph table shared with the processor
package io_responder_pkg;
  localparam logic [31:0] ADDR_IO_BASE = 32'hF000_0000;
  localparam logic [31:0] ADDR_HEX     = 32'hF000_0000;
  localparam logic [31:0] ADDR_LEDR    = 32'hF000_0004;
  localparam logic [31:0] ADDR_LEDG    = 32'hF000_0008;
  localparam logic [31:0] ADDR_KEY     = 32'hF000_0010;
  localparam logic [31:0] ADDR_SW      = 32'hF000_0014;
  localparam logic [31:0] ADDR_KEYEVT  = 32'hF000_0018;
  typedef logic [6:0] seg_t;
  // Active-low segments, bit0=a .. bit6=g, glyphs 0-9 then A b C d E F
  localparam seg_t SEG_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
endpackage

// File: rtl/io_responder_if.sv
// io_responder_if: processor data-bus port into the memory-mapped I/O block
interface io_responder_if #(parameter int DBITS = 32) ();
  logic [DBITS-1:0] addrIn;
  logic             wrtEn;
  logic [DBITS-1:0] dataIn;
  logic [DBITS-1:0] dataOut;
  logic             hit;
  modport master (output addrIn, wrtEn, dataIn, input dataOut, hit);
  modport slave  (input addrIn, wrtEn, dataIn, output dataOut, hit);
endinterface

// File: rtl/seven_seg_decoder.sv
// seven_seg_decoder: hex nibble to active-low 7-segment pattern
module seven_seg_decoder
  import io_responder_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       seg
);
  assign seg = SEG_GLYPH[nib];
endmodule

// File: rtl/io_responder.sv
// io_responder: memory-mapped HEX/LED outputs plus synchronized, debounced KEY/SW inputs
module io_responder
  import io_responder_pkg::*;
#(
  parameter logic [31:0] DEBOUNCE_CYCLES = 32'd50000,
  parameter int          DBITS           = 32
) (
  input  logic           clk,
  input  logic           reset,
  io_responder_if.slave  bus,
  input  logic [3:0]     KEY,
  input  logic [9:0]     SW,
  output logic [9:0]     LEDR,
  output logic [7:0]     LEDG,
  output logic [6:0]     HEX0,
  output logic [6:0]     HEX1,
  output logic [6:0]     HEX2,
  output logic [6:0]     HEX3
);
  localparam int NB = 14;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [NB-1:0] sync1_q, sync2_q, deb_q, deb_d;
  logic [CW-1:0] cnt_q [NB];
  logic [CW-1:0] cnt_d [NB];
  logic [15:0]   hex_q, hex_d;
  logic [9:0]    ledr_q, ledr_d;
  logic [7:0]    ledg_q, ledg_d;
  logic [3:0]    keyevt_q, keyevt_d;
  logic          m_hex, m_ledr, m_ledg, m_key, m_sw, m_evt, we;
  logic          unused_bits;
  assign unused_bits = ^bus.dataIn;
  // Counter clears at CMAX, so it never exceeds 2^CW-1 and cannot wrap
  for (genvar i = 0; i < NB; i++) begin : g_deb
    assign deb_d[i] = (sync2_q[i] != deb_q[i] && cnt_q[i] == CMAX) ? sync2_q[i] : deb_q[i];
    assign cnt_d[i] = (sync2_q[i] == deb_q[i] || cnt_q[i] == CMAX) ? '0 : cnt_q[i] + 1'b1;
  end
  always_comb begin
    m_hex  = bus.addrIn == DBITS'(ADDR_HEX);
    m_ledr = bus.addrIn == DBITS'(ADDR_LEDR);
    m_ledg = bus.addrIn == DBITS'(ADDR_LEDG);
    m_key  = bus.addrIn == DBITS'(ADDR_KEY);
    m_sw   = bus.addrIn == DBITS'(ADDR_SW);
    m_evt  = bus.addrIn == DBITS'(ADDR_KEYEVT);
    we     = bus.wrtEn;
    bus.hit = m_hex | m_ledr | m_ledg | m_key | m_sw | m_evt;
    bus.dataOut = m_hex  ? DBITS'(hex_q)
                : m_ledr ? DBITS'(ledr_q)
                : m_ledg ? DBITS'(ledg_q)
                : m_key  ? DBITS'(deb_q[3:0])
                : m_sw   ? DBITS'(deb_q[13:4])
                : m_evt  ? DBITS'(keyevt_q)
                : '0;
    hex_d  = (we && m_hex)  ? bus.dataIn[15:0] : hex_q;
    ledr_d = (we && m_ledr) ? bus.dataIn[9:0]  : ledr_q;
    ledg_d = (we && m_ledg) ? bus.dataIn[7:0]  : ledg_q;
    // A press landing on the same edge as its clear keeps the bit set
    keyevt_d = (keyevt_q & ~((we && m_evt) ? bus.dataIn[3:0] : 4'h0)) | (deb_d[3:0] & ~deb_q[3:0]);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      deb_q    <= '0;
      for (int k = 0; k < NB; k++) cnt_q[k] <= '0;
      hex_q    <= '0;
      ledr_q   <= '0;
      ledg_q   <= '0;
      keyevt_q <= '0;
    end else begin
      sync1_q  <= {SW, ~KEY};
      sync2_q  <= sync1_q;
      deb_q    <= deb_d;
      cnt_q    <= cnt_d;
      hex_q    <= hex_d;
      ledr_q   <= ledr_d;
      ledg_q   <= ledg_d;
      keyevt_q <= keyevt_d;
    end
  end
  assign LEDR = ledr_q;
  assign LEDG = ledg_q;
  seven_seg_decoder u_hex0 (.nib(hex_q[3:0]),   .seg(HEX0));
  seven_seg_decoder u_hex1 (.nib(hex_q[7:4]),   .seg(HEX1));
  seven_seg_decoder u_hex2 (.nib(hex_q[11:8]),  .seg(HEX2));
  seven_seg_decoder u_hex3 (.nib(hex_q[15:12]), .seg(HEX3));
endmodule

// File: tb/tb_io_responder.sv
// tb_io_responder: table-driven bus vectors plus debounce, KEYEVT and reset sequences
`timescale 1ns/1ps
module tb_io_responder;
  localparam logic [31:0] A_HEX = 32'hF000_0000, A_LEDR = 32'hF000_0004, A_LEDG = 32'hF000_0008;
  localparam logic [31:0] A_KEY = 32'hF000_0010, A_SW = 32'hF000_0014, A_EVT = 32'hF000_0018;
  localparam logic [31:0] A_BAD = 32'hF000_0020;
  logic clk = 0, reset;
  logic [3:0] KEY;
  logic [9:0] SW, LEDR;
  logic [7:0] LEDG;
  logic [6:0] HEX0, HEX1, HEX2, HEX3;
  int n_chk = 0, n_fail = 0;
  io_responder_if #(.DBITS(32)) bus ();
  io_responder #(.DEBOUNCE_CYCLES(32'd4), .DBITS(32)) dut (
    .clk(clk), .reset(reset), .bus(bus), .KEY(KEY), .SW(SW),
    .LEDR(LEDR), .LEDG(LEDG), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        we;
    logic [31:0] wa, wd, ra, rd;
    logic        hit;
    logic [9:0]  ledr;
    logic [7:0]  ledg;
    logic [27:0] hex;
  } vec_t;
  vec_t v [16];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus.wrtEn = 0;
    bus.addrIn = a;
    #1;
    chk(name, bus.dataOut, exp);
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.addrIn = a;
    bus.dataIn = d;
    bus.wrtEn = 1;
    tick(1);
    bus.wrtEn = 0;
  endtask
  initial begin
    v[0]  = '{1'b0, 32'h0,   32'h0,         A_HEX,  32'h0,    1'b1, 10'h0,   8'h0,  {7'h40, 7'h40, 7'h40, 7'h40}};
    v[1]  = '{1'b1, A_HEX,   32'h0000_BEEF, A_HEX,  32'hBEEF, 1'b1, 10'h0,   8'h0,  {7'h03, 7'h06, 7'h06, 7'h0E}};
    v[2]  = '{1'b1, A_LEDR,  32'hFFFF_FFFF, A_LEDR, 32'h3FF,  1'b1, 10'h3FF, 8'h0,  {7'h03, 7'h06, 7'h06, 7'h0E}};
    v[3]  = '{1'b1, A_LEDG,  32'h0000_01A5, A_LEDG, 32'hA5,   1'b1, 10'h3FF, 8'hA5, {7'h03, 7'h06, 7'h06, 7'h0E}};
    v[4]  = '{1'b1, A_SW,    32'hFFFF_FFFF, A_SW,   32'h0,    1'b1, 10'h3FF, 8'hA5, {7'h03, 7'h06, 7'h06, 7'h0E}};
    v[5]  = '{1'b1, A_KEY,   32'hFFFF_FFFF, A_KEY,  32'h0,    1'b1, 10'h3FF, 8'hA5, {7'h03, 7'h06, 7'h06, 7'h0E}};
    v[6]  = '{1'b1, A_BAD,   32'h1234_5678, A_BAD,  32'h0,    1'b0, 10'h3FF, 8'hA5, {7'h03, 7'h06, 7'h06, 7'h0E}};
    v[7]  = '{1'b0, 32'h0,   32'h0,         A_HEX,  32'hBEEF, 1'b1, 10'h3FF, 8'hA5, {7'h03, 7'h06, 7'h06, 7'h0E}};
    v[8]  = '{1'b1, A_HEX,   32'h1234_0123, A_HEX,  32'h0123, 1'b1, 10'h3FF, 8'hA5, {7'h40, 7'h79, 7'h24, 7'h30}};
    v[9]  = '{1'b1, A_HEX,   32'h0000_4567, A_HEX,  32'h4567, 1'b1, 10'h3FF, 8'hA5, {7'h19, 7'h12, 7'h02, 7'h78}};
    v[10] = '{1'b1, A_HEX,   32'h0000_89AC, A_HEX,  32'h89AC, 1'b1, 10'h3FF, 8'hA5, {7'h00, 7'h10, 7'h08, 7'h46}};
    v[11] = '{1'b1, A_HEX,   32'h0000_DF00, A_HEX,  32'hDF00, 1'b1, 10'h3FF, 8'hA5, {7'h21, 7'h0E, 7'h40, 7'h40}};
    v[12] = '{1'b1, A_LEDR,  32'h0000_0155, A_LEDR, 32'h155,  1'b1, 10'h155, 8'hA5, {7'h21, 7'h0E, 7'h40, 7'h40}};
    v[13] = '{1'b0, 32'h0,   32'h0,         A_EVT,  32'h0,    1'b1, 10'h155, 8'hA5, {7'h21, 7'h0E, 7'h40, 7'h40}};
    v[14] = '{1'b0, 32'h0,   32'h0,         32'hF000_0001, 32'h0, 1'b0, 10'h155, 8'hA5, {7'h21, 7'h0E, 7'h40, 7'h40}};
    v[15] = '{1'b1, A_EVT,   32'h0000_000F, A_EVT,  32'h0,    1'b1, 10'h155, 8'hA5, {7'h21, 7'h0E, 7'h40, 7'h40}};
    reset = 1; KEY = 4'hF; SW = '0;
    bus.addrIn = '0; bus.dataIn = '0; bus.wrtEn = 0;
    tick(2);
    reset = 0;
    for (int i = 0; i < 16; i++) begin
      bus.addrIn = v[i].wa;
      bus.dataIn = v[i].wd;
      bus.wrtEn = v[i].we;
      tick(1);
      rd($sformatf("vec%0d data", i), v[i].ra, v[i].rd);
      chk($sformatf("vec%0d hit", i), 32'(bus.hit), 32'(v[i].hit));
      chk($sformatf("vec%0d ledr", i), 32'(LEDR), 32'(v[i].ledr));
      chk($sformatf("vec%0d ledg", i), 32'(LEDG), 32'(v[i].ledg));
      chk($sformatf("vec%0d hex", i), 32'({HEX3, HEX2, HEX1, HEX0}), 32'(v[i].hex));
    end
    KEY = 4'b1011;
    for (int n = 1; n <= 6; n++) begin
      tick(1);
      rd($sformatf("key2 edge%0d", n), A_KEY, n == 6 ? 32'h4 : 32'h0);
      rd($sformatf("evt2 edge%0d", n), A_EVT, n == 6 ? 32'h4 : 32'h0);
    end
    KEY = 4'hF;
    tick(8);
    rd("key2 released", A_KEY, 32'h0);
    rd("evt2 sticky", A_EVT, 32'h4);
    for (int c = 0; c < 10; c++) begin
      SW[0] = ~SW[0];
      tick(2);
      rd($sformatf("sw bounce%0d", c), A_SW, 32'h0);
    end
    SW = 10'h2A5;
    tick(7);
    rd("sw stable", A_SW, 32'h2A5);
    SW = '0;
    tick(7);
    rd("sw cleared", A_SW, 32'h0);
    KEY = 4'h0;
    tick(8);
    KEY = 4'hF;
    tick(8);
    rd("evt all", A_EVT, 32'hF);
    wr(A_EVT, 32'h5);
    rd("evt clr5", A_EVT, 32'hA);
    wr(A_EVT, 32'h0);
    rd("evt clr0", A_EVT, 32'hA);
    KEY = 4'b1110;
    tick(5);
    rd("key0 pre", A_KEY, 32'h0);
    wr(A_EVT, 32'h1);
    rd("evt set wins", A_EVT, 32'hB);
    rd("key0 post", A_KEY, 32'h1);
    KEY = 4'hF;
    tick(8);
    wr(A_LEDR, 32'h3FF);
    chk("ledr before rst", 32'(LEDR), 32'h3FF);
    KEY = 4'b1101;
    tick(3);
    #2 reset = 1;
    #1 chk("ledr async rst", 32'(LEDR), 32'h0);
    chk("hex async rst", 32'({HEX3, HEX2, HEX1, HEX0}), 32'({7'h40, 7'h40, 7'h40, 7'h40}));
    KEY = 4'hF;
    tick(2);
    reset = 0;
    tick(10);
    rd("evt after rst", A_EVT, 32'h0);
    rd("key after rst", A_KEY, 32'h0);
    rd("ledr after rst", A_LEDR, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
